// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and defaults for the req/ack CDC handshake endpoints
package cdc_pkg;

  localparam int CDC_DATA_W = 32;
  localparam int CDC_CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_ACK     = 2'd2
  } hs_state_e;

endpackage

// File: rtl/cdc_hs_rx.sv
// rtl/cdc_hs_rx.sv - destination endpoint of a four-phase req/ack handshake, delivering the word on valid/ready
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W = CDC_DATA_W,
  parameter int CNT_W  = CDC_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_sync,
  input  logic [DATA_W-1:0] src_data,
  output logic              ack,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              proto_err,
  input  logic              err_clr
);

  hs_state_e         state_q, state_d;
  logic              ack_q, ack_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic              err_set;
  logic              accept;

  assign accept = m_valid_q && m_ready;

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    xfer_cnt_d = xfer_cnt_q;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_sync) begin
          m_data_d  = src_data;
          m_valid_d = 1'b1;
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // A request withdrawn before ack is flagged, but the word is still delivered
        if (!req_sync) err_set = 1'b1;
        if (accept) begin
          m_valid_d  = 1'b0;
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
          if (req_sync) begin
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
      end
    endcase
    proto_err_d = (proto_err_q && !err_clr) || err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      xfer_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      xfer_cnt_q  <= xfer_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ack       = ack_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// tb/tb_cdc_hs_rx.sv - directed bench for cdc_hs_rx with a 4-bit transfer counter
module tb_cdc_hs_rx;

  logic        clk;
  logic        rst_n;
  logic        req_sync;
  logic [31:0] src_data;
  logic        ack;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic [3:0]  xfer_cnt;
  logic        proto_err;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  cdc_hs_rx #(.DATA_W(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_sync  (req_sync),
    .src_data  (src_data),
    .ack       (ack),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .xfer_cnt  (xfer_cnt),
    .proto_err (proto_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req_sync = 1'b0;
    src_data = 32'h0;
    m_ready  = 1'b0;
    err_clr  = 1'b0;
    step();
    step();
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_valid", {31'b0, m_valid}, 32'd0);
    check("rst_data", m_data, 32'h0);
    check("rst_cnt", {28'b0, xfer_cnt}, 32'd0);
    check("rst_err", {31'b0, proto_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // single transfer with m_ready tied high
    src_data = 32'hDEADBEEF;
    req_sync = 1'b1;
    m_ready  = 1'b1;
    step();
    check("t1_valid", {31'b0, m_valid}, 32'd1);
    check("t1_data", m_data, 32'hDEADBEEF);
    check("t1_ack_pre", {31'b0, ack}, 32'd0);
    step();
    check("t1_valid_drop", {31'b0, m_valid}, 32'd0);
    check("t1_ack", {31'b0, ack}, 32'd1);
    check("t1_cnt", {28'b0, xfer_cnt}, 32'd1);
    step();
    check("t1_ack_hold", {31'b0, ack}, 32'd1);
    check("t1_no_recap", {31'b0, m_valid}, 32'd0);
    req_sync = 1'b0;
    step();
    check("t1_ack_rel", {31'b0, ack}, 32'd0);
    check("t1_err", {31'b0, proto_err}, 32'd0);

    // backpressure, source word changes are ignored while presenting
    m_ready  = 1'b0;
    src_data = 32'h12345678;
    req_sync = 1'b1;
    step();
    check("bp_valid", {31'b0, m_valid}, 32'd1);
    check("bp_data", m_data, 32'h12345678);
    src_data = 32'hAAAAAAAA;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", {31'b0, m_valid}, 32'd1);
      check("bp_hold_data", m_data, 32'h12345678);
      check("bp_hold_ack", {31'b0, ack}, 32'd0);
    end
    m_ready = 1'b1;
    step();
    check("bp_ack", {31'b0, ack}, 32'd1);
    check("bp_valid_drop", {31'b0, m_valid}, 32'd0);
    check("bp_cnt", {28'b0, xfer_cnt}, 32'd2);
    src_data = 32'h55555555;
    step();
    step();
    check("ack_no_recap_valid", {31'b0, m_valid}, 32'd0);
    check("ack_no_recap_data", m_data, 32'h12345678);
    req_sync = 1'b0;
    step();
    check("bp_ack_rel", {31'b0, ack}, 32'd0);
    step();
    check("idle_hold", {31'b0, m_valid}, 32'd0);

    // withdrawal before accept
    m_ready  = 1'b0;
    src_data = 32'hCAFEF00D;
    req_sync = 1'b1;
    step();
    check("wd_valid", {31'b0, m_valid}, 32'd1);
    req_sync = 1'b0;
    step();
    check("wd_err", {31'b0, proto_err}, 32'd1);
    check("wd_valid_hold", {31'b0, m_valid}, 32'd1);
    check("wd_data", m_data, 32'hCAFEF00D);
    check("wd_ack", {31'b0, ack}, 32'd0);
    m_ready = 1'b1;
    step();
    check("wd_delivered", {31'b0, m_valid}, 32'd0);
    check("wd_cnt", {28'b0, xfer_cnt}, 32'd3);
    check("wd_ack_after", {31'b0, ack}, 32'd0);
    err_clr = 1'b1;
    step();
    check("wd_clr", {31'b0, proto_err}, 32'd0);
    check("wd_idle_ack", {31'b0, ack}, 32'd0);
    err_clr = 1'b0;

    // back in IDLE: a new request captures; then accept and withdrawal coincide with err_clr
    m_ready  = 1'b0;
    src_data = 32'h0BADF00D;
    req_sync = 1'b1;
    step();
    check("sim_capture", m_data, 32'h0BADF00D);
    check("sim_valid", {31'b0, m_valid}, 32'd1);
    m_ready  = 1'b1;
    req_sync = 1'b0;
    err_clr  = 1'b1;
    step();
    check("sim_err_wins", {31'b0, proto_err}, 32'd1);
    check("sim_ack", {31'b0, ack}, 32'd0);
    check("sim_valid_drop", {31'b0, m_valid}, 32'd0);
    check("sim_cnt", {28'b0, xfer_cnt}, 32'd4);
    err_clr = 1'b0;
    step();
    check("sim_ack_later", {31'b0, ack}, 32'd0);
    check("sim_err_sticky", {31'b0, proto_err}, 32'd1);

    // async reset between edges, then 17 transfers wrap the 4-bit counter
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_err", {31'b0, proto_err}, 32'd0);
    check("arst_cnt", {28'b0, xfer_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      src_data = 32'h100 + i;
      req_sync = 1'b1;
      step();
      check("wrap_data", m_data, 32'h100 + i);
      step();
      check("wrap_ack", {31'b0, ack}, 32'd1);
      if (i == 15) check("wrap_zero", {28'b0, xfer_cnt}, 32'd0);
      req_sync = 1'b0;
      step();
    end
    check("wrap_cnt", {28'b0, xfer_cnt}, 32'd1);

    // async reset while in ACK with the request still high
    src_data = 32'hFEEDFACE;
    req_sync = 1'b1;
    step();
    check("ar_capture", m_data, 32'hFEEDFACE);
    step();
    check("ar_ack_up", {31'b0, ack}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ack_async", {31'b0, ack}, 32'd0);
    check("ar_valid_async", {31'b0, m_valid}, 32'd0);
    check("ar_data_async", m_data, 32'h0);
    check("ar_cnt_async", {28'b0, xfer_cnt}, 32'd0);
    src_data = 32'h13579BDF;
    step();
    rst_n = 1'b1;
    step();
    check("ar_recap_valid", {31'b0, m_valid}, 32'd1);
    check("ar_recap_data", m_data, 32'h13579BDF);
    check("ar_recap_ack", {31'b0, ack}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
